// File: rtl/conv_mem_host.sv
// conv_mem_host: memory-side responder for the CONV accelerator.
// Holds the image ROM (host loadable), the L0 (4096 words) and L1 (1024 words)
// layer banks, the ready/busy start handshake, a watchdog and a dump port.
// All reads have one cycle of latency through registered outputs.
module conv_mem_host #(
   parameter int TIMEOUT = 1048576
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_en,
   input  logic [11:0] ld_addr,
   input  logic [19:0] ld_data,
   input  logic        start,
   output logic        ready,
   input  logic        busy,
   input  logic [11:0] iaddr,
   output logic [19:0] idata,
   input  logic        cwr,
   input  logic [11:0] caddr_wr,
   input  logic [19:0] cdata_wr,
   input  logic        crd,
   input  logic [11:0] caddr_rd,
   output logic [19:0] cdata_rd,
   input  logic [2:0]  csel,
   input  logic        dmp_sel,
   input  logic [11:0] dmp_addr,
   output logic [19:0] dmp_data,
   output logic        done,
   output logic        timeout,
   output logic        csel_err,
   output logic [12:0] wr_cnt0,
   output logic [10:0] wr_cnt1
);

   typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_t;

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t            r_state;
   state_t            w_next;
   logic [WD_W-1:0]   r_wd;
   logic [19:0]       r_img [0:4095];
   logic [19:0]       r_l0  [0:4095];
   logic [19:0]       r_l1  [0:1023];
   logic [19:0]       r_idata;
   logic [19:0]       r_cdata_rd;
   logic [19:0]       r_dmp_data;
   logic              r_done;
   logic              r_timeout;
   logic              r_csel_err;
   logic [12:0]       r_wr_cnt0;
   logic [10:0]       r_wr_cnt1;

   logic w_active, w_run, w_wd_exp, w_enter_ready, w_img_we;
   logic w_wr_l0, w_wr_l1, w_wr_bad, w_rd_l0, w_rd_l1, w_rd_bad;

   assign w_active      = (r_state == S_READY) || (r_state == S_RUN);
   assign w_run         = (r_state == S_RUN);
   assign w_wd_exp      = w_active && (r_wd == WD_W'(TIMEOUT - 1));
   assign w_enter_ready = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
   assign w_img_we      = (r_state == S_IDLE) && ld_en;

   // L1 is only 1024 deep: addresses with bits [11:10] set are illegal
   assign w_wr_l0  = w_run && cwr && (csel == 3'b001);
   assign w_wr_l1  = w_run && cwr && (csel == 3'b011) && (caddr_wr[11:10] == 2'b00);
   assign w_wr_bad = w_run && cwr && !w_wr_l0 && !w_wr_l1;
   assign w_rd_l0  = w_run && crd && (csel == 3'b001);
   assign w_rd_l1  = w_run && crd && (csel == 3'b011) && (caddr_rd[11:10] == 2'b00);
   assign w_rd_bad = w_run && crd && !w_rd_l0 && !w_rd_l1;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state logic; the watchdog overrides the handshake in READY/RUN
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_READY;
         S_READY: if (w_wd_exp) w_next = S_IDLE;
                  else if (busy) w_next = S_RUN;
         S_RUN:   if (w_wd_exp) w_next = S_IDLE;
                  else if (!busy) w_next = S_DONE;
         S_DONE:  if (start) w_next = S_READY;
         default: w_next = S_IDLE;
      endcase
   end

   // watchdog: cleared on entering READY, counts every cycle in READY/RUN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      r_wd <= '0;
      else if (w_enter_ready)         r_wd <= '0;
      else if (w_active && !w_wd_exp) r_wd <= r_wd + 1'b1;
   end

   // run status flags and saturating write counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
         r_csel_err <= 1'b0;
         r_wr_cnt0  <= '0;
         r_wr_cnt1  <= '0;
      end else begin
         if (w_wd_exp) r_timeout <= 1'b1;
         if (w_enter_ready) begin
            r_done     <= 1'b0;
            r_csel_err <= 1'b0;
            r_wr_cnt0  <= '0;
            r_wr_cnt1  <= '0;
         end else begin
            if (w_run && (w_next == S_DONE)) r_done <= 1'b1;
            if (w_wr_bad || w_rd_bad)        r_csel_err <= 1'b1;
            if (w_wr_l0 && (r_wr_cnt0 != '1)) r_wr_cnt0 <= r_wr_cnt0 + 1'b1;
            if (w_wr_l1 && (r_wr_cnt1 != '1)) r_wr_cnt1 <= r_wr_cnt1 + 1'b1;
         end
      end
   end

   // registered read ports; a same-cycle write is not yet visible (old data)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idata    <= '0;
         r_cdata_rd <= '0;
         r_dmp_data <= '0;
      end else begin
         r_idata <= (busy && w_active) ? r_img[iaddr] : 20'd0;
         if (w_rd_l0)      r_cdata_rd <= r_l0[caddr_rd];
         else if (w_rd_l1) r_cdata_rd <= r_l1[caddr_rd[9:0]];
         r_dmp_data <= dmp_sel ? r_l1[dmp_addr[9:0]] : r_l0[dmp_addr];
      end
   end

   // memory arrays: contents survive reset
   always_ff @(posedge clk) begin
      if (w_img_we) r_img[ld_addr]        <= ld_data;
      if (w_wr_l0)  r_l0[caddr_wr]        <= cdata_wr;
      if (w_wr_l1)  r_l1[caddr_wr[9:0]]   <= cdata_wr;
   end

   assign ready    = (r_state == S_READY);
   assign idata    = r_idata;
   assign cdata_rd = r_cdata_rd;
   assign dmp_data = r_dmp_data;
   assign done     = r_done;
   assign timeout  = r_timeout;
   assign csel_err = r_csel_err;
   assign wr_cnt0  = r_wr_cnt0;
   assign wr_cnt1  = r_wr_cnt1;

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: inputs change 1ns after a rising edge,
// outputs are checked at that same point, after the edge has settled.
module tb_conv_mem_host;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_en;
   logic [11:0] ld_addr;
   logic [19:0] ld_data;
   logic        start;
   logic        ready;
   logic        busy;
   logic [11:0] iaddr;
   logic [19:0] idata;
   logic        cwr;
   logic [11:0] caddr_wr;
   logic [19:0] cdata_wr;
   logic        crd;
   logic [11:0] caddr_rd;
   logic [19:0] cdata_rd;
   logic [2:0]  csel;
   logic        dmp_sel;
   logic [11:0] dmp_addr;
   logic [19:0] dmp_data;
   logic        done;
   logic        timeout;
   logic        csel_err;
   logic [12:0] wr_cnt0;
   logic [10:0] wr_cnt1;

   int checks = 0;
   int errors = 0;

   conv_mem_host #(.TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
      .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel), .dmp_sel(dmp_sel),
      .dmp_addr(dmp_addr), .dmp_data(dmp_data), .done(done), .timeout(timeout),
      .csel_err(csel_err), .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ready"},    {31'd0, ready},    32'd0);
      chk({tag, ".idata"},    {12'd0, idata},    32'd0);
      chk({tag, ".cdata_rd"}, {12'd0, cdata_rd}, 32'd0);
      chk({tag, ".dmp_data"}, {12'd0, dmp_data}, 32'd0);
      chk({tag, ".done"},     {31'd0, done},     32'd0);
      chk({tag, ".timeout"},  {31'd0, timeout},  32'd0);
      chk({tag, ".csel_err"}, {31'd0, csel_err}, 32'd0);
      chk({tag, ".wr_cnt0"},  {19'd0, wr_cnt0},  32'd0);
      chk({tag, ".wr_cnt1"},  {21'd0, wr_cnt1},  32'd0);
   endtask

   initial begin
      reset = 1'b1; ld_en = 0; ld_addr = 0; ld_data = 0; start = 0; busy = 0;
      iaddr = 0; cwr = 0; caddr_wr = 0; cdata_wr = 0; crd = 0; caddr_rd = 0;
      csel = 3'b001; dmp_sel = 0; dmp_addr = 0;
      tick(); tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // image load in IDLE: img[k] = k
      for (int k = 0; k < 4096; k++) begin
         ld_en = 1'b1; ld_addr = 12'(k); ld_data = 20'(k);
         tick();
      end
      ld_en = 1'b0;
      tick();

      // handshake: ready one cycle after start, falls one cycle after busy
      start = 1'b1; tick(); start = 1'b0;
      chk("ready_rise", {31'd0, ready}, 32'd1);
      tick(); tick();
      chk("ready_hold", {31'd0, ready}, 32'd1);
      busy = 1'b1; iaddr = 12'h123; tick();
      chk("ready_fall", {31'd0, ready}, 32'd0);
      chk("idata_123", {12'd0, idata}, 32'h00123);
      iaddr = 12'hFFF; tick();
      chk("idata_fff", {12'd0, idata}, 32'h00FFF);

      // L0 write then read back
      cwr = 1; csel = 3'b001; caddr_wr = 12'h0AB; cdata_wr = 20'h12345; tick();
      cwr = 0; crd = 1; caddr_rd = 12'h0AB; tick(); crd = 0;
      chk("l0_rdback", {12'd0, cdata_rd}, 32'h12345);
      // L1 top word
      cwr = 1; csel = 3'b011; caddr_wr = 12'h3FF; cdata_wr = 20'hFFFFF; tick(); cwr = 0;
      chk("cnt0_1", {19'd0, wr_cnt0}, 32'd1);
      chk("cnt1_1", {21'd0, wr_cnt1}, 32'd1);
      chk("err_clean", {31'd0, csel_err}, 32'd0);
      cwr = 1; csel = 3'b011; caddr_wr = 12'h000; cdata_wr = 20'h0AAAA; tick(); cwr = 0;

      // illegal csel write: nothing written, sticky error
      cwr = 1; csel = 3'b010; caddr_wr = 12'h0AB; cdata_wr = 20'h00001; tick(); cwr = 0;
      chk("err_csel010", {31'd0, csel_err}, 32'd1);
      chk("cnt0_after_bad", {19'd0, wr_cnt0}, 32'd1);
      crd = 1; csel = 3'b001; caddr_rd = 12'h0AB; tick(); crd = 0;
      chk("l0_not_clobbered", {12'd0, cdata_rd}, 32'h12345);
      // L1 out-of-range write must not alias onto L1[0]
      cwr = 1; csel = 3'b011; caddr_wr = 12'h400; cdata_wr = 20'h77777; tick(); cwr = 0;
      chk("cnt1_after_oor", {21'd0, wr_cnt1}, 32'd2);
      crd = 1; csel = 3'b011; caddr_rd = 12'h000; tick(); crd = 0;
      chk("l1_0_unchanged", {12'd0, cdata_rd}, 32'h0AAAA);
      // illegal csel read holds the previous value
      crd = 1; csel = 3'b111; caddr_rd = 12'h0AB; tick(); crd = 0;
      chk("rd_csel111_hold", {12'd0, cdata_rd}, 32'h0AAAA);

      // same-address write+read: old data, then new data
      cwr = 1; csel = 3'b001; caddr_wr = 12'h007; cdata_wr = 20'h11111; tick();
      cdata_wr = 20'h55555; crd = 1; caddr_rd = 12'h007; tick(); cwr = 0;
      chk("collide_old", {12'd0, cdata_rd}, 32'h11111);
      tick(); crd = 0;
      chk("collide_new", {12'd0, cdata_rd}, 32'h55555);

      // image load locked out while running
      ld_en = 1; ld_addr = 12'h123; ld_data = 20'hABCDE; tick(); ld_en = 0;
      iaddr = 12'h123; tick();
      chk("ld_lockout", {12'd0, idata}, 32'h00123);

      // busy drop: done one cycle later and held
      busy = 1'b0; tick();
      chk("done_rise", {31'd0, done}, 32'd1);
      chk("idata_idle_zero", {12'd0, idata}, 32'd0);
      for (int i = 0; i < 9; i++) tick();
      chk("done_held", {31'd0, done}, 32'd1);
      chk("cnt0_final", {19'd0, wr_cnt0}, 32'd3);
      chk("cnt1_final", {21'd0, wr_cnt1}, 32'd2);

      // dump port
      dmp_sel = 1; dmp_addr = 12'h3FF; tick();
      chk("dump_l1_3ff", {12'd0, dmp_data}, 32'hFFFFF);
      dmp_sel = 0; dmp_addr = 12'h0AB; tick();
      chk("dump_l0_0ab", {12'd0, dmp_data}, 32'h12345);

      // restart from DONE clears run state; busy never comes -> watchdog
      start = 1'b1; tick(); start = 1'b0;
      chk("rerun_ready", {31'd0, ready}, 32'd1);
      chk("rerun_cnt0", {19'd0, wr_cnt0}, 32'd0);
      chk("rerun_done", {31'd0, done}, 32'd0);
      chk("rerun_err", {31'd0, csel_err}, 32'd0);
      for (int i = 0; i < 63; i++) tick();
      chk("wd_not_yet", {31'd0, timeout}, 32'd0);
      chk("wd_ready_still", {31'd0, ready}, 32'd1);
      tick();
      chk("wd_fire", {31'd0, timeout}, 32'd1);
      chk("wd_ready_drop", {31'd0, ready}, 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      chk("wd_sticky", {31'd0, timeout}, 32'd1);

      // reset mid-RUN: outputs drop asynchronously
      busy = 1'b1; iaddr = 12'h123; tick();
      chk("run_idata", {12'd0, idata}, 32'h00123);
      #2 reset = 1'b1;
      #1 chk_all_zero("midrun_reset");
      tick(); reset = 1'b0; busy = 1'b0;
      tick();

      // back in IDLE: image load accepted again
      ld_en = 1; ld_addr = 12'h123; ld_data = 20'h54321; tick(); ld_en = 0;
      start = 1'b1; tick(); start = 1'b0;
      chk("post_reset_ready", {31'd0, ready}, 32'd1);
      busy = 1'b1; iaddr = 12'h123; tick();
      chk("post_reset_load", {12'd0, idata}, 32'h54321);
      busy = 1'b0; tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // hard bound on simulated time
   initial begin
      #2000000;
      $display("FAIL timeout_bound: observed simulation still running expected finish");
      $fatal(1, "bench time limit");
   end

endmodule
